// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: bridges a simple cache read/write request interface onto
// AXI. Independent read FSM (AR/R) and write FSM (AW/W/B), each with at
// most one transaction in flight.
// Optional feature: define BRIDGE_RAW_CHECK_EN so that a read cannot be
// accepted while a write to the same 16-byte line is still pending.
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    // cache read side
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    // cache write side
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         data_write_ok,
    // AXI AR
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic         arvalid,
    input  logic         arready,
    // AXI R
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // AXI AW
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic         awvalid,
    input  logic         awready,
    // AXI W / B
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

    r_state_t       r_state_reg, r_state_next;
    w_state_t       w_state_reg, w_state_next;
    logic [31:0]    rd_addr_reg;
    logic [2:0]     rd_type_reg;
    logic [31:0]    wr_addr_reg;
    logic [2:0]     wr_type_reg;
    logic [3:0]     wr_strb_reg;
    logic [127:0]   wr_data_reg;
    logic [1:0]     cnt_reg;
    logic           aw_done_reg;
    logic           w_done_reg;

    logic           rd_line, wr_line;
    logic           raw_block;
    logic           rd_accept, wr_accept;
    logic           aw_hs, w_hs, w_last_hs;
    logic           aw_complete, w_complete;
    logic [31:0]    wr_word [4];
    logic           rid_unused;

    // Responses carry a single outstanding read, so the ID is not needed.
    assign rid_unused = ^rid;

    assign rd_line = (rd_type_reg == 3'd4);
    assign wr_line = (wr_type_reg == 3'd4);

`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_block = (w_state_reg != W_IDLE) && (rd_addr[31:4] == wr_addr_reg[31:4]);
`else
    assign raw_block = 1'b0;
`endif

    assign rd_rdy    = (r_state_reg == R_IDLE) && !raw_block;
    assign wr_rdy    = (w_state_reg == W_IDLE);
    assign rd_accept = rd_req && rd_rdy;
    assign wr_accept = wr_req && wr_rdy;

    // AR / R channel outputs; return beats pass straight through.
    assign arid      = RD_ID;
    assign araddr    = rd_addr_reg;
    assign arlen     = rd_line ? 8'd3 : 8'd0;
    assign arsize    = rd_line ? 3'd2 : {1'b0, rd_type_reg[1:0]};
    assign arvalid   = (r_state_reg == R_AR);
    assign rready    = (r_state_reg == R_DATA);
    assign ret_valid = rready && rvalid;
    assign ret_last  = rready && rlast;
    assign ret_data  = rdata;

    // Split the latched line into words for beat selection.
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        assign wr_word[gi] = wr_data_reg[32*gi +: 32];
    end

    // AW / W / B channel outputs; AW and W progress independently.
    assign awid      = WR_ID;
    assign awaddr    = wr_addr_reg;
    assign awlen     = wr_line ? 8'd3 : 8'd0;
    assign awsize    = wr_line ? 3'd2 : {1'b0, wr_type_reg[1:0]};
    assign awvalid   = (w_state_reg == W_SEND) && !aw_done_reg;
    assign wvalid    = (w_state_reg == W_SEND) && !w_done_reg;
    assign wdata     = wr_word[cnt_reg];
    assign wstrb     = wr_line ? 4'hf : wr_strb_reg;
    assign wlast     = (cnt_reg == awlen[1:0]);
    assign bready    = (w_state_reg == W_RESP);
    assign data_write_ok = bready && bvalid;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_last_hs   = w_hs && wlast;
    assign aw_complete = aw_done_reg || aw_hs;
    assign w_complete  = w_done_reg || w_last_hs;

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_reg <= R_IDLE;
            w_state_reg <= W_IDLE;
        end else begin
            r_state_reg <= r_state_next;
            w_state_reg <= w_state_next;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (rd_accept) r_state_next = R_AR;
            R_AR:    if (arready) r_state_next = R_DATA;
            R_DATA:  if (rvalid && rlast) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Write FSM next state; leave W_SEND only once both AW and last W are done.
    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (wr_accept) w_state_next = W_SEND;
            W_SEND:  if (aw_complete && w_complete) w_state_next = W_RESP;
            W_RESP:  if (bvalid) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Latch read request fields on acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr_reg <= 32'd0;
            rd_type_reg <= 3'd0;
        end else if (rd_accept) begin
            rd_addr_reg <= rd_addr;
            rd_type_reg <= rd_type;
        end
    end

    // Latch write request, then track beat count and per-channel completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_addr_reg <= 32'd0;
            wr_type_reg <= 3'd0;
            wr_strb_reg <= 4'd0;
            wr_data_reg <= 128'd0;
            cnt_reg     <= 2'd0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else if (wr_accept) begin
            wr_addr_reg <= wr_addr;
            wr_type_reg <= wr_type;
            wr_strb_reg <= wr_wstrb;
            wr_data_reg <= wr_data;
            cnt_reg     <= 2'd0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else if (w_state_reg == W_SEND) begin
            if (w_hs)      cnt_reg     <= cnt_reg + 2'd1;
            if (aw_hs)     aw_done_reg <= 1'b1;
            if (w_last_hs) w_done_reg  <= 1'b1;
        end
    end

endmodule
